// File: rtl/bit_sample_count_receive.sv
// Oversampling serial character receiver: synchronizes the line, qualifies the
// start bit at mid-bit, samples data bits LSB-first and checks the stop bit.
module bit_sample_count_receive #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rx_s;

    // Two-flop synchronizer runs every clock, independent of sample_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (sample_tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: begin
                        // Re-check the line half a bit in; a high line was a glitch.
                        if (cnt_q == MID_LAST) begin
                            cnt_q <= '0;
                            if (rx_s) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= DATA;
                                bit_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    DATA: begin
                        if (cnt_q == BIT_LAST) begin
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= '0;
                            bit_q   <= bit_q + BIT_ONE;
                            if (bit_q == DATA_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    STOP: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q <= '0;
                            if (rx_s) begin
                                rx_data_q <= shift_q;
                                valid_q   <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= BREAK;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    BREAK: begin
                        // Wait out a held-low line so it is not seen as new starts.
                        if (rx_s) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != IDLE);

endmodule
